// File: rtl/decode_issue.sv
// Decode/issue stage: 8x19 register file, hazard stall, S2 writeback bypass, LDI handling.
// Optional DECODE_STATS_EN adds issue_cnt/stall_cnt performance counters.
module decode_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [18:0] instr,
  output logic        instr_ready,
  output logic [5:0]  opcode,
  output logic [18:0] r2,
  output logic [18:0] r3,
  output logic [2:0]  imm,
  output logic        aluen,
  input  logic [18:0] alu_r1,
  input  logic [7:0]  alu_flag,
  output logic [7:0]  flag_q,
  input  logic [2:0]  dbg_rsel,
  output logic [18:0] dbg_rdata
`ifdef DECODE_STATS_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int         STAGES = 2;
  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_LDI = 6'b111110;

  typedef struct packed {
    logic [5:0] op;
    logic [2:0] rd;
    logic [2:0] rs2;
    logic [2:0] rs3;
    logic [2:0] imm;
    logic       rsvd;
  } instr_t;

  instr_t            dec;
  logic [7:0][18:0]  rf;
  logic [STAGES:1]   vld_pipe;
  logic [2:0]        s1_rd, s2_rd;
  logic              is_ldi, is_alu, stall, accept, issue, wb;
  logic [18:0]       op2, op3;
  logic              unused_rsvd;

  assign dec         = instr_t'(instr);
  assign unused_rsvd = dec.rsvd;
  assign is_ldi      = (dec.op == OP_LDI);
  assign is_alu      = (dec.op != OP_NOP) && !is_ldi;

  // S1 result is not yet available for bypass; hold RAW readers and LDI WAW writers one cycle
  assign stall = vld_pipe[1] && (s1_rd != '0) &&
                 ((is_alu && (dec.rs2 == s1_rd || dec.rs3 == s1_rd)) ||
                  (is_ldi && dec.rd == s1_rd));

  assign instr_ready = !stall;
  assign accept      = instr_valid && instr_ready;
  assign issue       = accept && is_alu;
  assign wb          = vld_pipe[STAGES] && (s2_rd != '0);

  assign op2 = (wb && s2_rd == dec.rs2) ? alu_r1 : rf[dec.rs2];
  assign op3 = (wb && s2_rd == dec.rs3) ? alu_r1 : rf[dec.rs3];

  assign aluen     = vld_pipe[1];
  assign dbg_rdata = rf[dbg_rsel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      s1_rd    <= '0;
      s2_rd    <= '0;
      opcode   <= '0;
      r2       <= '0;
      r3       <= '0;
      imm      <= '0;
      flag_q   <= '0;
      rf       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], issue};
      s2_rd    <= s1_rd;
      if (issue) begin
        s1_rd  <= dec.rd;
        opcode <= dec.op;
        r2     <= op2;
        r3     <= op3;
        imm    <= dec.imm;
      end
      if (vld_pipe[STAGES]) flag_q <= alu_flag;
      if (wb) rf[s2_rd] <= alu_r1;
      // LDI is younger than the S2 writeback, so it is ordered last and wins a same-rd collision
      if (accept && is_ldi && dec.rd != '0) rf[dec.rd] <= {10'b0, instr[9:1]};
    end
  end

`ifdef DECODE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (aluen) issue_cnt <= issue_cnt + 16'd1;
      if (instr_valid && !instr_ready) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
